// File: rtl/burst_ram_pkg.sv
// Shared types and constants for the burst RAM responder.
package burst_ram_pkg;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_WAIT,
        RD_BURST,
        WR_BURST
    } state_t;

    localparam logic CmdRead   = 1'b0;
    localparam logic CmdWrite  = 1'b1;
    localparam int   BeatBytes = 8;

endpackage

// File: rtl/burst_ram_array.sv
// Single-port 64-bit word array with per-byte write inhibit mask and a
// registered read port. The read register returns zero in cycles without a read.
// Contents are not reset.
module burst_ram_array
    import burst_ram_pkg::*;
#(
    parameter int AddressBitWidth = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       we,
    input  logic                       re,
    input  logic [AddressBitWidth-1:0] addr,
    input  logic [63:0]                wr_data,
    input  logic [BeatBytes-1:0]       wr_mask,
    output logic [63:0]                rd_data
);

    logic [63:0] mem [0:(1<<AddressBitWidth)-1];

    // Byte-granular write: a set mask bit leaves that byte untouched
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BeatBytes; b++) begin
                if (!wr_mask[b]) mem[addr][b*8 +: 8] <= wr_data[b*8 +: 8];
            end
        end
    end

    // Registered read; output forced to zero when not reading
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     rd_data <= '0;
        else if (re) rd_data <= mem[addr];
        else         rd_data <= '0;
    end

endmodule

// File: rtl/burst_ram_responder.sv
// Memory-side responder for the br_ burst RAM interface: fixed-length
// read/write bursts with a fixed read latency and an init/calibration delay.
// Optional BURST_RAM_RESPONDER_PROTOCOL_CHECK_EN adds a sticky protocol_error.
module burst_ram_responder
    import burst_ram_pkg::*;
#(
    parameter int AddressBitWidth       = 10,
    parameter int DataBitWidth          = 64,
    parameter int BurstDataCount        = 4,
    parameter int CyclesBeforeDataValid = 6,
    parameter int CyclesInitCalib       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cmd,
    input  logic                         cmd_en,
    input  logic [AddressBitWidth-1:0]   addr,
    input  logic [DataBitWidth-1:0]      wr_data,
    input  logic [DataBitWidth/8-1:0]    data_mask,
    output logic [DataBitWidth-1:0]      rd_data,
    output logic                         rd_data_valid,
    output logic                         busy,
    output logic                         init_calib,
    output logic                         protocol_error
);

    localparam int CntW  = 16;
    localparam int BeatW = (BurstDataCount > 1) ? $clog2(BurstDataCount) : 1;

    state_t                     state;
    logic [CntW-1:0]            cnt;
    logic [BeatW-1:0]           beat;
    logic [AddressBitWidth-1:0] addr_q;

    logic                       mem_we;
    logic                       mem_re;
    logic [BeatW-1:0]           idx;
    logic [AddressBitWidth-1:0] mem_addr;

    // Control FSM: init delay, read latency wait, beat sequencing
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= INIT;
            cnt        <= '0;
            beat       <= '0;
            addr_q     <= '0;
            busy       <= 1'b0;
            init_calib <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (cnt == CntW'(CyclesInitCalib - 1)) begin
                        state      <= IDLE;
                        init_calib <= 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                IDLE: begin
                    if (cmd_en) begin
                        addr_q <= addr;
                        cnt    <= '0;
                        if (cmd == CmdWrite) begin
                            // beat 0 is written in the accept cycle itself
                            if (BurstDataCount > 1) begin
                                state <= WR_BURST;
                                beat  <= BeatW'(1);
                                busy  <= 1'b1;
                            end
                        end else begin
                            state <= RD_WAIT;
                            busy  <= 1'b1;
                        end
                    end
                end
                RD_WAIT: begin
                    // array read for beat 0 issues here, one cycle ahead of valid
                    if (cnt == CntW'(CyclesBeforeDataValid - 2)) begin
                        state <= RD_BURST;
                        beat  <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RD_BURST, WR_BURST: begin
                    if (beat == BeatW'(BurstDataCount - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // Array access decode; reads run one beat ahead because the array output is registered
    always_comb begin
        mem_we = 1'b0;
        mem_re = 1'b0;
        idx    = '0;
        case (state)
            IDLE:     mem_we = cmd_en && (cmd == CmdWrite);
            RD_WAIT:  mem_re = (cnt == CntW'(CyclesBeforeDataValid - 2));
            RD_BURST: begin
                if (beat != BeatW'(BurstDataCount - 1)) begin
                    mem_re = 1'b1;
                    idx    = beat + 1'b1;
                end
            end
            WR_BURST: begin
                mem_we = 1'b1;
                idx    = beat;
            end
            default: ;
        endcase
    end

    // Address arithmetic truncates to AW bits, so bursts wrap at the top of the array
    assign mem_addr = (state == IDLE) ? addr : addr_q + AddressBitWidth'(idx);

    // Valid follows the array read by one cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_data_valid <= 1'b0;
        else     rd_data_valid <= mem_re;
    end

    burst_ram_array #(
        .AddressBitWidth (AddressBitWidth)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .we      (mem_we),
        .re      (mem_re),
        .addr    (mem_addr),
        .wr_data (wr_data),
        .wr_mask (data_mask),
        .rd_data (rd_data)
    );

`ifdef BURST_RAM_RESPONDER_PROTOCOL_CHECK_EN
    logic viol;

    // Command offered while not accepting, or with unknown cmd/addr
    always_comb begin
        viol = cmd_en && (busy || !init_calib);
`ifndef SYNTHESIS
        if (cmd_en === 1'b1 && $isunknown({cmd, addr})) viol = 1'b1;
`endif
    end

    // Sticky violation flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            protocol_error <= 1'b0;
        end else if (viol) begin
            protocol_error <= 1'b1;
`ifndef SYNTHESIS
            $error("burst_ram_responder: protocol violation at %0t addr=%h", $time, addr);
`endif
        end
    end
`else
    assign protocol_error = 1'b0;
`endif

endmodule

// File: tb/tb_burst_ram_responder.sv
// Directed bench for burst_ram_responder with a reference word model and a
// per-read expected-beat queue.
module tb_burst_ram_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd;
    logic        cmd_en;
    logic [9:0]  addr;
    logic [63:0] wr_data;
    logic [7:0]  data_mask;
    logic [63:0] rd_data;
    logic        rd_data_valid;
    logic        busy;
    logic        init_calib;
    logic        protocol_error;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] model [0:1023];
    logic        perr_exp;

    burst_ram_responder #(
        .AddressBitWidth       (10),
        .DataBitWidth          (64),
        .BurstDataCount        (4),
        .CyclesBeforeDataValid (6),
        .CyclesInitCalib       (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd            (cmd),
        .cmd_en         (cmd_en),
        .addr           (addr),
        .wr_data        (wr_data),
        .data_mask      (data_mask),
        .rd_data        (rd_data),
        .rd_data_valid  (rd_data_valid),
        .busy           (busy),
        .init_calib     (init_calib),
        .protocol_error (protocol_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Release reset and watch the calibration delay (16 cycles)
    task automatic init_seq();
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk($sformatf("init_calib_k%0d", k), init_calib, (k == 16));
            chk("init_busy", busy, 1'b0);
            chk("init_valid", rd_data_valid, 1'b0);
        end
    endtask

    // Called at a negedge; returns at the negedge of cycle T+4 (first free cycle)
    task automatic do_write(input logic [9:0] a, input logic [3:0][63:0] d, input logic [7:0] m);
        for (int i = 0; i < 4; i++)
            for (int b = 0; b < 8; b++)
                if (!m[b]) model[10'(a + 10'(i))][b*8 +: 8] = d[i][b*8 +: 8];
        cmd_en = 1'b1; cmd = 1'b1; addr = a; wr_data = d[0]; data_mask = m;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            cmd_en  = 1'b0;
            wr_data = d[i];
            chk("wr_busy", busy, 1'b1);
        end
        @(negedge clk);
        wr_data = '0;
        chk("wr_done_busy", busy, 1'b0);
        chk("wr_valid", rd_data_valid, 1'b0);
    endtask

    // Read burst; optional illegal cmd pulse at cycle T+pulse_k, optional reset at T+rst_k
    task automatic do_read(input logic [9:0] a, input int pulse_k, input int rst_k);
        logic [63:0] exp_q [$];
        logic [63:0] e;
        for (int i = 0; i < 4; i++) exp_q.push_back(model[10'(a + 10'(i))]);
        cmd_en = 1'b1; cmd = 1'b0; addr = a;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            cmd_en = 1'b0;
            if (k == pulse_k) begin
                cmd_en = 1'b1; cmd = 1'b1; addr = a;
                wr_data = 64'hDEAD_BEEF_DEAD_BEEF; data_mask = 8'h00;
            end
            if (k == rst_k) begin
                rst = 1'b1;
                #1;
                chk("rst_mid_valid", rd_data_valid, 1'b0);
                chk("rst_mid_data", rd_data, 64'h0);
                chk("rst_mid_busy", busy, 1'b0);
                chk("rst_mid_init", init_calib, 1'b0);
                chk("rst_mid_perr", protocol_error, 1'b0);
                return;
            end
            chk($sformatf("rd_busy_k%0d", k), busy, (k <= 9));
            chk($sformatf("rd_valid_k%0d", k), rd_data_valid, (k >= 6 && k <= 9));
            if (rd_data_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rd_extra_beat", 64'h1, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("rd_beat_%h_k%0d", a, k), rd_data, e);
                end
            end else begin
                chk("rd_idle_data", rd_data, 64'h0);
            end
        end
        chk("rd_beats_left", 64'(exp_q.size()), 64'h0);
    endtask

    initial begin
        rst = 1'b1; cmd = 1'b0; cmd_en = 1'b0; addr = '0; wr_data = '0; data_mask = '0;
`ifdef BURST_RAM_RESPONDER_PROTOCOL_CHECK_EN
        perr_exp = 1'b1;
`else
        perr_exp = 1'b0;
`endif

        // 1: reset state and calibration delay
        repeat (2) @(negedge clk);
        chk("rst_data", rd_data, 64'h0);
        chk("rst_valid", rd_data_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_init", init_calib, 1'b0);
        chk("rst_perr", protocol_error, 1'b0);
        init_seq();

        // 2: full write then read back (back-to-back)
        @(negedge clk);
        do_write(10'h010, {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 8'h00);
        do_read(10'h010, 0, 0);

        // 3: masked write over zeroed words
        do_write(10'h020, {4{64'h0}}, 8'h00);
        do_write(10'h020, {4{64'hFFFF_FFFF_FFFF_FFFF}}, 8'hF0);
        chk("mask_model", model[10'h021], 64'h0000_0000_FFFF_FFFF);
        do_read(10'h020, 0, 0);

        // 4: wrap at top of array, for both write and read
        do_write(10'h3FE, {64'hA3A3_0000_0000_0003, 64'hA2A2_0000_0000_0002,
                           64'hA1A1_0000_0000_0001, 64'hA0A0_0000_0000_0000}, 8'h00);
        do_read(10'h3FE, 0, 0);
        do_read(10'h000, 0, 0);

        // 5: command offered mid-read is ignored
        chk("perr_before", protocol_error, 1'b0);
        do_read(10'h010, 2, 0);
        chk("perr_after", protocol_error, perr_exp);
        do_read(10'h010, 0, 0);

        // 6: reset mid-burst, contents retained
        do_read(10'h020, 0, 7);
        init_seq();
        chk("perr_cleared", protocol_error, 1'b0);
        @(negedge clk);
        do_read(10'h020, 0, 0);
        do_read(10'h3FE, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
